// File: rtl/mult_hazard_unit.sv
// Pipeline stall/bubble controller: freezes the front end while a multi-cycle
// multiply occupies EX and bubbles load-use dependencies that forwarding cannot cover.
module mult_hazard_unit #(
  parameter int unsigned MULT_LAT = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_is_mult,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mult_busy,
  output logic             mult_done,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE,
    MBUSY
  } state_t;

  localparam bit         MULTI_CYCLE = (MULT_LAT > 1);
  localparam logic [3:0] CNT_INIT    = 4'(MULTI_CYCLE ? MULT_LAT - 2 : 0);

  state_t     state;
  logic [3:0] cnt;
  logic       mult_stall;
  logic       mult_last;
  logic       load_stall;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_stall = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    mult_stall = 1'b0;
    mult_last  = 1'b0;
    case (state)
      IDLE: begin
        if (MULTI_CYCLE) mult_stall = ex_is_mult;
        else             mult_last  = ex_is_mult;
      end
      MBUSY: begin
        if (cnt != 4'd0) mult_stall = 1'b1;
        else             mult_last  = 1'b1;
      end
    endcase
  end

  // Reset overrides the hazard logic so the pipeline can flush freely.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mult_busy     = 1'b0;
    mult_done     = 1'b0;
    if (!rst) begin
      pc_write      = ~(mult_stall | load_stall);
      if_id_write   = ~(mult_stall | load_stall);
      id_ex_write   = ~mult_stall;
      id_ex_bubble  = load_stall & ~mult_stall;
      ex_mem_bubble = mult_stall;
      mult_busy     = mult_stall;
      mult_done     = mult_last;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      stall_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MULTI_CYCLE && ex_is_mult) begin
            state <= MBUSY;
            cnt   <= CNT_INIT;
          end
        end
        MBUSY: begin
          if (cnt != 4'd0) cnt   <= cnt - 4'd1;
          else             state <= IDLE;
        end
      endcase
      if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_hazard_unit.sv
// Self-checking bench for mult_hazard_unit: directed cycle table, randomized run
// against an occupancy-based reference model, and counter saturation.
module tb_mult_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_is_mult, ex_mem_read, id_uses_rs1, id_uses_rs2;
  logic [4:0] ex_rd, id_rs1, id_rs2;

  logic        a_pc, a_ifid, a_idex, a_bub, a_emb, a_busy, a_done;
  logic [31:0] a_sc;
  logic        b_pc, b_ifid, b_idex, b_bub, b_emb, b_busy, b_done;
  logic [3:0]  b_sc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mult_hazard_unit #(.MULT_LAT(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ex_is_mult(ex_is_mult), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .pc_write(a_pc), .if_id_write(a_ifid), .id_ex_write(a_idex),
    .id_ex_bubble(a_bub), .ex_mem_bubble(a_emb), .mult_busy(a_busy),
    .mult_done(a_done), .stall_cycles(a_sc)
  );

  mult_hazard_unit #(.MULT_LAT(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .ex_is_mult(ex_is_mult), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .pc_write(b_pc), .if_id_write(b_ifid), .id_ex_write(b_idex),
    .id_ex_bubble(b_bub), .ex_mem_bubble(b_emb), .mult_busy(b_busy),
    .mult_done(b_done), .stall_cycles(b_sc)
  );

  typedef struct {
    logic       rst, mul, mrd;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic       pc, idew, bub, emb, busy, done;
    int         sc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, m, mr, input logic [4:0] rd, r1, r2,
                              input logic u1, u2, pc, idew, bub, emb, busy, done,
                              input int sc);
    vec_t v;
    v.rst = r;  v.mul = m;   v.mrd = mr; v.rd = rd; v.rs1 = r1; v.rs2 = r2;
    v.u1 = u1;  v.u2 = u2;   v.pc = pc;  v.idew = idew; v.bub = bub;
    v.emb = emb; v.busy = busy; v.done = done; v.sc = sc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, m, mr, input logic [4:0] rd, r1, r2,
                       input logic u1, u2);
    rst = r; ex_is_mult = m; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
  endtask

  // Reference model: each instance tracks how many more cycles the current
  // multiply still holds EX (0 = EX free) and a saturating stall tally.
  int     lat[2]  = '{3, 1};
  longint maxc[2] = '{64'hFFFF_FFFF, 64'd15};
  int     rem[2];
  longint cnt[2];

  task automatic model_check_and_step();
    logic ls, ms, md, pcw;
    int   occ;
    logic o_pc[2], o_ifid[2], o_idex[2], o_bub[2], o_emb[2], o_busy[2], o_done[2];
    longint o_sc[2];
    int   occ_k[2];
    logic pcw_k[2];
    @(negedge clk);
    o_pc   = '{a_pc, b_pc};     o_ifid = '{a_ifid, b_ifid}; o_idex = '{a_idex, b_idex};
    o_bub  = '{a_bub, b_bub};   o_emb  = '{a_emb, b_emb};   o_busy = '{a_busy, b_busy};
    o_done = '{a_done, b_done}; o_sc   = '{longint'(a_sc), longint'(b_sc)};
    ls = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    for (int k = 0; k < 2; k++) begin
      occ = (rem[k] > 0) ? rem[k] : (ex_is_mult ? lat[k] : 0);
      ms  = !rst && occ > 1;
      md  = !rst && occ == 1;
      pcw = rst || !(ms || ls);
      check($sformatf("rnd%0d pc_write", k),      o_pc[k],   pcw);
      check($sformatf("rnd%0d if_id_write", k),   o_ifid[k], pcw);
      check($sformatf("rnd%0d id_ex_write", k),   o_idex[k], !ms);
      check($sformatf("rnd%0d id_ex_bubble", k),  o_bub[k],  !rst && ls && !ms);
      check($sformatf("rnd%0d ex_mem_bubble", k), o_emb[k],  ms);
      check($sformatf("rnd%0d mult_busy", k),     o_busy[k], ms);
      check($sformatf("rnd%0d mult_done", k),     o_done[k], md);
      check($sformatf("rnd%0d stall_cycles", k),  o_sc[k],   cnt[k]);
      occ_k[k] = occ;
      pcw_k[k] = pcw;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k] = 0;
        cnt[k] = 0;
      end else begin
        rem[k] = (occ_k[k] > 0) ? occ_k[k] - 1 : 0;
        if (!pcw_k[k] && cnt[k] < maxc[k]) cnt[k]++;
      end
    end
    #1;
  endtask

  initial begin
    // Directed cycle table for the MULT_LAT=3 instance (idw follows pc).
    add(1,0,0,0,0,0,0,0, 1,1,0,0,0,0, 0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 0);
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 0);
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 1);
    add(0,1,0,0,0,0,0,0, 1,1,0,0,0,1, 2);
    add(0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 2);
    add(0,0,1,5,5,1,1,0, 0,1,1,0,0,0, 2);   // load x5 -> add x6,x5,x1
    add(0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 3);
    add(0,0,1,0,0,0,1,1, 1,1,0,0,0,0, 3);   // load to x0 never stalls
    add(0,0,1,7,3,7,0,1, 0,1,1,0,0,0, 3);   // rs2 dependency
    add(0,0,1,7,3,7,0,0, 1,1,0,0,0,0, 4);   // rs2 match but unused
    add(0,1,1,5,5,0,1,0, 0,0,0,1,1,0, 4);   // multiply masks load bubble
    add(0,1,1,5,5,0,1,0, 0,0,0,1,1,0, 5);
    add(0,1,1,5,5,0,1,0, 0,1,1,0,0,1, 6);   // release: load-use takes over
    add(0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 7);
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 7);   // back-to-back multiplies
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 8);
    add(0,1,0,0,0,0,0,0, 1,1,0,0,0,1, 9);
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 9);
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 10);
    add(0,1,0,0,0,0,0,0, 1,1,0,0,0,1, 11);
    add(0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 11);
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 11);  // multiply aborted by reset
    add(1,1,1,5,5,0,1,0, 1,1,0,0,0,0, 12);
    add(0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 0);
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 0);   // fresh multiply after reset
    add(0,1,0,0,0,0,0,0, 0,0,0,1,1,0, 1);
    add(0,1,0,0,0,0,0,0, 1,1,0,0,0,1, 2);
    add(0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 2);

    drive(1,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].mul, vecs[i].mrd, vecs[i].rd, vecs[i].rs1,
            vecs[i].rs2, vecs[i].u1, vecs[i].u2);
      @(negedge clk);
      check($sformatf("vec%0d pc_write", i),      a_pc,   vecs[i].pc);
      check($sformatf("vec%0d if_id_write", i),   a_ifid, vecs[i].pc);
      check($sformatf("vec%0d id_ex_write", i),   a_idex, vecs[i].idew);
      check($sformatf("vec%0d id_ex_bubble", i),  a_bub,  vecs[i].bub);
      check($sformatf("vec%0d ex_mem_bubble", i), a_emb,  vecs[i].emb);
      check($sformatf("vec%0d mult_busy", i),     a_busy, vecs[i].busy);
      check($sformatf("vec%0d mult_done", i),     a_done, vecs[i].done);
      check($sformatf("vec%0d stall_cycles", i),  a_sc,   longint'(vecs[i].sc));
      @(posedge clk); #1;
    end

    // Randomized run for both instances against the reference model.
    drive(1,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin rem[k] = 0; cnt[k] = 0; end
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      model_check_and_step();
    end

    // Saturation: a held load-use stall for 20 cycles pins the 4-bit counter at 15.
    drive(1,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    drive(0,0,1,9,9,0,1,0);
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    check("sat small stall_cycles", b_sc, 15);
    check("sat wide stall_cycles",  a_sc, 20);
    check("sat pc_write held low",  b_pc, 0);
    drive(1,0,1,9,9,0,1,0);
    @(posedge clk); #1;
    drive(0,0,0,0,0,0,0,0);
    @(negedge clk);
    check("sat reset clears small", b_sc, 0);
    check("sat reset clears wide",  a_sc, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
